// File: rtl/internal_lustre_serial_adder_pkg.sv
// Shared definitions for the Lustre serial arithmetic blocks: the control
// state encodings and the digit-counter sizing rule.
package internal_lustre_serial_adder_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Digit counter width: clog2 of the digit count, never narrower than 1 bit.
  function automatic int cnt_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/internal_lustre_adder.sv
// Combinational N-bit adder/subtractor with Z/N/C/V flags. Used by the serial
// adder as its K-bit digit slice.
module internal_lustre_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  input  logic         carry_in,
  input  logic         sub,
  output logic [N-1:0] res,
  output logic         flag_Z,
  output logic         flag_N,
  output logic         flag_C,
  output logic         flag_V
);

  logic [N-1:0] rhs_eff;
  logic [N:0]   sum;

  // One extra bit on the sum exposes the carry out of bit N-1.
  always_comb begin
    rhs_eff = sub ? ~rhs : rhs;
    sum     = {1'b0, lhs} + {1'b0, rhs_eff} + {{N{1'b0}}, carry_in};
  end

  // The carry into the top bit is recovered from the top sum bit and its operands.
  assign res    = sum[N-1:0];
  assign flag_C = sum[N];
  assign flag_V = sum[N] ^ (sum[N-1] ^ lhs[N-1] ^ rhs_eff[N-1]);
  assign flag_N = sum[N-1];
  assign flag_Z = ~|sum[N-1:0];

endmodule

// File: rtl/internal_lustre_serial_adder.sv
// Digit-serial adder/subtractor: adds two N-bit operands K bits per cycle
// through a single K-bit adder slice, with valid/ready handshakes on both
// sides and the same Z/N/C/V semantics as the full-width adder.
module internal_lustre_serial_adder
  import internal_lustre_serial_adder_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  input  logic         carry_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] res,
  output logic         flag_Z,
  output logic         flag_N,
  output logic         flag_C,
  output logic         flag_V
);

  localparam int D  = N / K;
  localparam int CW = cnt_width(D);
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  if (K < 1 || K > N || (N % K) != 0) begin : g_bad_params
    $error("internal_lustre_serial_adder: K must divide N with 1 <= K <= N");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          carry;
  logic [N-1:0]  lhs_sr;
  logic [N-1:0]  rhs_sr;
  logic [K-1:0]  d_sum;
  logic          d_z;
  logic          d_n;
  logic          d_c;
  logic          d_v;
  logic [N-1:0]  rest;
  logic          last;

  // Operands are pre-inverted at accept, so the slice always adds.
  internal_lustre_adder #(.N(K)) u_digit (
    .lhs      (lhs_sr[K-1:0]),
    .rhs      (rhs_sr[K-1:0]),
    .carry_in (carry),
    .sub      (1'b0),
    .res      (d_sum),
    .flag_Z   (d_z),
    .flag_N   (d_n),
    .flag_C   (d_c),
    .flag_V   (d_v)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last      = (cnt == LAST);

  // Result with the current digit cleared; zero here plus a zero digit means a zero result.
  always_comb begin
    rest = res;
    rest[cnt*K +: K] = '0;
  end

  // Control: state sequencing, digit counter and inter-digit carry.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= BUSY;
            cnt   <= '0;
            carry <= carry_in;
          end
        end
        BUSY: begin
          carry <= d_c;
          if (last) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: operand shift registers, digit write-back and final flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lhs_sr <= '0;
      rhs_sr <= '0;
      res    <= '0;
      flag_Z <= 1'b0;
      flag_N <= 1'b0;
      flag_C <= 1'b0;
      flag_V <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      lhs_sr <= lhs;
      rhs_sr <= sub ? ~rhs : rhs;
    end else if (state == BUSY) begin
      lhs_sr <= N'(lhs_sr >> K);
      rhs_sr <= N'(rhs_sr >> K);
      res[cnt*K +: K] <= d_sum;
      if (last) begin
        flag_C <= d_c;
        flag_V <= d_v;
        flag_N <= d_n;
        flag_Z <= d_z & ~|rest;
      end
    end
  end

endmodule

// File: tb/tb_internal_lustre_serial_adder.sv
// Directed bench for the digit-serial adder: K=4, K=1 and K=8 instances share
// one stimulus stream; expected values are hand-computed or from a golden sum.
module tb_internal_lustre_serial_adder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       carry_in;
  logic       sub;
  logic       out_ready;
  logic [7:0] lhs;
  logic [7:0] rhs;

  logic       ir4, ov4, z4, n4, c4, v4;
  logic [7:0] r4;
  logic       ir1, ov1, z1, n1, c1, v1;
  logic [7:0] r1;
  logic       ir8, ov8, z8, n8, c8, v8;
  logic [7:0] r8;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  internal_lustre_serial_adder #(.N(8), .K(4)) u_k4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir4),
    .lhs(lhs), .rhs(rhs), .carry_in(carry_in), .sub(sub),
    .out_valid(ov4), .out_ready(out_ready), .res(r4),
    .flag_Z(z4), .flag_N(n4), .flag_C(c4), .flag_V(v4)
  );

  internal_lustre_serial_adder #(.N(8), .K(1)) u_k1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
    .lhs(lhs), .rhs(rhs), .carry_in(carry_in), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .res(r1),
    .flag_Z(z1), .flag_N(n1), .flag_C(c1), .flag_V(v1)
  );

  internal_lustre_serial_adder #(.N(8), .K(8)) u_k8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir8),
    .lhs(lhs), .rhs(rhs), .carry_in(carry_in), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready), .res(r8),
    .flag_Z(z8), .flag_N(n8), .flag_C(c8), .flag_V(v8)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden reference: {res, Z, N, C, V} from a 9-bit sum.
  function automatic logic [11:0] model(input logic [7:0] l, input logic [7:0] r,
                                        input logic c, input logic s);
    logic [7:0] re;
    logic [8:0] sum;
    logic       v;
    re  = s ? ~r : r;
    sum = {1'b0, l} + {1'b0, re} + {8'd0, c};
    v   = (l[7] == re[7]) && (sum[7] != l[7]);
    return {sum[7:0], (sum[7:0] == 8'd0), sum[7], sum[8], v};
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // One K=4 operation: accept, wait for the result, check it, drain.
  task automatic op4(input string tag, input logic [7:0] l, input logic [7:0] r,
                     input logic c, input logic s, input logic [7:0] er, input logic [3:0] ef);
    int lat;
    chk({tag, "_in_ready"}, ir4, 1);
    lhs = l; rhs = r; carry_in = c; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; lhs = 8'($urandom); rhs = 8'($urandom);
    lat = 0;
    while (!ov4 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, 2);
    chk({tag, "_res"}, r4, er);
    chk({tag, "_flags"}, {z4, n4, c4, v4}, ef);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, ir4, 1);
    chk({tag, "_idle_out_valid"}, ov4, 0);
  endtask

  initial begin
    int lat1, lat4, lat8;
    int lat;
    logic [7:0]  l, r;
    logic        c, s;
    logic [11:0] g;

    reset_n = 1'b0; in_valid = 1'b0; lhs = '0; rhs = '0;
    carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    tick();
    chk("rst_in_ready", ir4, 1);
    chk("rst_out_valid", ov4, 0);
    chk("rst_res", r4, 0);
    chk("rst_flags", {z4, n4, c4, v4}, 0);
    reset_n = 1'b1;
    tick();

    // 0x7F + 0x01: exact two-edge latency, then backpressure in DONE.
    lhs = 8'h7F; rhs = 8'h01; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("add_busy_in_ready", ir4, 0);
    chk("add_e1_out_valid", ov4, 0);
    tick();
    chk("add_e1b_out_valid", ov4, 0);
    tick();
    chk("add_e2_out_valid", ov4, 1);
    chk("add_res", r4, 8'h80);
    chk("add_flags", {z4, n4, c4, v4}, 4'b0101);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; lhs = 8'($urandom); rhs = 8'($urandom);
      tick();
      chk("bp_out_valid", ov4, 1);
      chk("bp_in_ready", ir4, 0);
      chk("bp_res", r4, 8'h80);
      chk("bp_flags", {z4, n4, c4, v4}, 4'b0101);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_drain_in_ready", ir4, 1);
    chk("bp_drain_out_valid", ov4, 0);

    // Subtract mode.
    op4("sub_eq", 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 4'b1010);
    op4("sub_ovf", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 4'b0011);

    // Digit-width extremes: 0xFF + 0x01 on K=1, K=4 and K=8 together.
    do_reset();
    lhs = 8'hFF; rhs = 8'h01; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat1 = -1; lat4 = -1; lat8 = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (ov1 && lat1 < 0) lat1 = e;
      if (ov4 && lat4 < 0) lat4 = e;
      if (ov8 && lat8 < 0) lat8 = e;
    end
    chk("k1_latency", lat1, 8);
    chk("k4_latency", lat4, 2);
    chk("k8_latency", lat8, 1);
    chk("k1_res", r1, 8'h00);
    chk("k1_flags", {z1, n1, c1, v1}, 4'b1010);
    chk("k4_res", r4, 8'h00);
    chk("k4_flags", {z4, n4, c4, v4}, 4'b1010);
    chk("k8_res", r8, 8'h00);
    chk("k8_flags", {z8, n8, c8, v8}, 4'b1010);

    // Reset while processing digit 1 of 2.
    do_reset();
    lhs = 8'h33; rhs = 8'h44; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("midrst_busy_out_valid", ov4, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", ir4, 1);
    chk("midrst_out_valid", ov4, 0);
    chk("midrst_res", r4, 0);
    chk("midrst_flags", {z4, n4, c4, v4}, 0);
    tick();
    reset_n = 1'b1;
    tick();
    op4("post_rst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 4'b0000);

    // Back-to-back sweep with out_ready tied high.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      l = 8'($urandom); r = 8'($urandom); c = 1'($urandom); s = 1'($urandom);
      g = model(l, r, c, s);
      chk("sweep_in_ready", ir4, 1);
      lhs = l; rhs = r; carry_in = c; sub = s; in_valid = 1'b1;
      tick();
      lhs = 8'($urandom); rhs = 8'($urandom);
      lat = 0;
      while (!ov4 && lat < 20) begin
        tick();
        lat++;
      end
      chk("sweep_latency", lat, 2);
      chk("sweep_res", r4, g[11:4]);
      chk("sweep_flags", {z4, n4, c4, v4}, g[3:0]);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
